// File: rtl/seg7_scan.sv
// Multiplexed 7-segment scanner: per-digit hex glyph, decimal point and blanking.
// Optional `SEG7_LEADING_ZERO_BLANK_EN darkens zero digits above the highest non-zero nibble.
module seg7_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  load,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an,
  output logic                  frame_done
);

  localparam int unsigned DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [DW-1:0]       div_q, div_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [4*DIGITS-1:0] val_q, val_d;
  logic [DIGITS-1:0]   dpin_q, dpin_d;
  logic [DIGITS-1:0]   blank_q, blank_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                wrap_q, wrap_d;
  logic                frame_done_q, frame_done_d;

  logic                tc;
  logic                last_idx;
  logic [3:0]          nib;
  logic                cur_dp;
  logic                cur_blank;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic                zero_above;
`endif

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;
      4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;
      4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;
      4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;
      4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;
      4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;
      4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;
      4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;
      default: glyph = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    tc       = (div_q == DW'(REFRESH_DIV - 1));
    last_idx = (idx_q == IW'(DIGITS - 1));
    div_d    = tc ? '0 : div_q + DW'(1);
    idx_d    = idx_q;
    if (tc) idx_d = last_idx ? '0 : idx_q + IW'(1);

    // Wrap is delayed one cycle so the pulse lines up with digit 0 reaching the outputs.
    wrap_d       = tc && last_idx;
    frame_done_d = wrap_q;

    val_d   = load ? value : val_q;
    dpin_d  = load ? dp_in : dpin_q;
    blank_d = load ? blank : blank_q;

    nib       = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        nib       = val_q[4*k +: 4];
        cur_dp    = dpin_q[k];
        cur_blank = blank_q[k];
      end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    zero_above = 1'b1;
    for (int unsigned i = DIGITS; i > 0; i--) begin
      zero_above = zero_above && (val_q[4*(i-1) +: 4] == 4'h0);
      if ((i > 1) && zero_above && (idx_q == IW'(i - 1))) cur_blank = 1'b1;
    end
`endif

    an_d  = '1;
    seg_d = '1;
    dp_d  = 1'b1;
    if (!cur_blank) begin
      for (int unsigned k = 0; k < DIGITS; k++) an_d[k] = (idx_q != IW'(k));
      seg_d = glyph(nib);
      dp_d  = !cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q        <= '0;
      idx_q        <= '0;
      val_q        <= '0;
      dpin_q       <= '0;
      blank_q      <= '0;
      seg_q        <= '1;
      dp_q         <= 1'b1;
      an_q         <= '1;
      wrap_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      div_q        <= div_d;
      idx_q        <= idx_d;
      val_q        <= val_d;
      dpin_q       <= dpin_d;
      blank_q      <= blank_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      wrap_q       <= wrap_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Bench for seg7_scan (DIGITS=4, REFRESH_DIV=4): constant vector table, corner sequences,
// and randomized traffic checked against an edge-count based reference model.
module tb_seg7_scan;
  localparam int D = 4;
  localparam int R = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank = '0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  seg7_scan #(.DIGITS(D), .REFRESH_DIV(R)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .dp_in(dp_in), .blank(blank),
    .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [6:0] glyph_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model state: edges since reset release plus shadow copies of the last load.
  int          m_n = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic        e_dp, e_fd;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic [3:0]  blank;
    int          slot;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
  } vec_t;
  vec_t tab[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    int k;
    logic [15:0] hi;
    logic blk;
    @(posedge clk);
    if (rst) begin
      e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      k   = (m_n / R) % D;
      hi  = m_val >> (4 * k);
      blk = m_blank[k];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
      if (k > 0 && hi == 16'h0) blk = 1'b1;
`endif
      if (blk) begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end else begin
        e_an  = ~(4'b0001 << k);
        e_seg = glyph_tab[hi[3:0]];
        e_dp  = ~m_dp[k];
      end
      e_fd = (m_n > 0) && (m_n % (R * D) == 0);
    end
    if (rst) begin
      m_n = 0; m_val = '0; m_dp = '0; m_blank = '0;
    end else begin
      m_n++;
      if (load) begin
        m_val = value; m_dp = dp_in; m_blank = blank;
      end
    end
    #1;
    chk("model", {21'd0, an, seg, dp, frame_done}, {21'd0, e_an, e_seg, e_dp, e_fd});
  endtask

  task automatic sync_to(input int k);
    for (int i = 0; i < 2 * R * D && (m_n % (R * D)) != k * R; i++) step();
    chk("sync_timeout", (m_n % (R * D)), k * R);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
    value = v; dp_in = d; blank = b; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    int pulses;

    tab.push_back('{16'h12AB, 4'b0100, 4'b0000, 0, 4'b1110, 7'b0000011, 1'b1});
    tab.push_back('{16'h12AB, 4'b0100, 4'b0000, 1, 4'b1101, 7'b0001000, 1'b1});
    tab.push_back('{16'h12AB, 4'b0100, 4'b0000, 2, 4'b1011, 7'b0100100, 1'b0});
    tab.push_back('{16'h12AB, 4'b0100, 4'b0000, 3, 4'b0111, 7'b1111001, 1'b1});
    tab.push_back('{16'h8888, 4'b0000, 4'b0100, 0, 4'b1110, 7'b0000000, 1'b1});
    tab.push_back('{16'h8888, 4'b0000, 4'b0100, 1, 4'b1101, 7'b0000000, 1'b1});
    tab.push_back('{16'h8888, 4'b0000, 4'b0100, 2, 4'b1111, 7'b1111111, 1'b1});
    tab.push_back('{16'h8888, 4'b0000, 4'b0100, 3, 4'b0111, 7'b0000000, 1'b1});
    tab.push_back('{16'h3C5E, 4'b1111, 4'b0000, 0, 4'b1110, 7'b0000110, 1'b0});
    tab.push_back('{16'h3C5E, 4'b1111, 4'b0000, 1, 4'b1101, 7'b0010010, 1'b0});
    tab.push_back('{16'h3C5E, 4'b1111, 4'b0000, 2, 4'b1011, 7'b1000110, 1'b0});
    tab.push_back('{16'h3C5E, 4'b1111, 4'b0000, 3, 4'b0111, 7'b0110000, 1'b0});
    tab.push_back('{16'h7D4F, 4'b0001, 4'b0000, 0, 4'b1110, 7'b0001110, 1'b0});
    tab.push_back('{16'h7D4F, 4'b0001, 4'b0000, 1, 4'b1101, 7'b0011001, 1'b1});
    tab.push_back('{16'h7D4F, 4'b0001, 4'b0000, 2, 4'b1011, 7'b0100001, 1'b1});
    tab.push_back('{16'h7D4F, 4'b0001, 4'b0000, 3, 4'b0111, 7'b1111000, 1'b1});
    tab.push_back('{16'h9600, 4'b0000, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1});
    tab.push_back('{16'h9600, 4'b0000, 4'b0000, 1, 4'b1101, 7'b1000000, 1'b1});
    tab.push_back('{16'h9600, 4'b0000, 4'b0000, 2, 4'b1011, 7'b0000010, 1'b1});
    tab.push_back('{16'h9600, 4'b0000, 4'b0000, 3, 4'b0111, 7'b0010000, 1'b1});
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    tab.push_back('{16'h00A0, 4'b0000, 4'b0000, 3, 4'b1111, 7'b1111111, 1'b1});
    tab.push_back('{16'h00A0, 4'b0000, 4'b0000, 2, 4'b1111, 7'b1111111, 1'b1});
`else
    tab.push_back('{16'h00A0, 4'b0000, 4'b0000, 3, 4'b0111, 7'b1000000, 1'b1});
    tab.push_back('{16'h00A0, 4'b0000, 4'b0000, 2, 4'b1011, 7'b1000000, 1'b1});
`endif
    tab.push_back('{16'h00A0, 4'b0000, 4'b0000, 1, 4'b1101, 7'b0001000, 1'b1});
    tab.push_back('{16'h00A0, 4'b0000, 4'b0000, 0, 4'b1110, 7'b1000000, 1'b1});

    // Reset held three cycles, then release.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_an", an, 4'hF);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_dp", dp, 1'b1);
      chk("rst_fd", frame_done, 1'b0);
    end
    rst = 1'b0;
    step();
    chk("rel_an", an, 4'b1110);
    chk("rel_seg", seg, 7'b1000000);

    // Free run: frame_done at edges 17 and 33 after release, with digit 0 on display.
    pulses = 0;
    for (int s = 2; s <= 40; s++) begin
      step();
      if (frame_done) begin
        pulses++;
        chk("fd_pos", s, 1 + 16 * pulses);
        chk("fd_an", an, 4'b1110);
      end
    end
    chk("fd_count", pulses, 2);

    foreach (tab[i]) begin
      do_load(tab[i].value, tab[i].dp_in, tab[i].blank);
      sync_to(tab[i].slot);
      for (int c = 0; c < R; c++) begin
        step();
        chk("tab_an", an, tab[i].an);
        chk("tab_seg", seg, tab[i].seg);
        chk("tab_dp", dp, tab[i].dp);
      end
    end

    // Load mid-slot: new glyph one cycle later, slot timing untouched.
    do_load(16'h0000, 4'b0000, 4'b0000);
    sync_to(1);
    step(); chk("mid_an0", an, 4'b1101); chk("mid_seg0", seg, 7'b1000000);
    step(); chk("mid_an1", an, 4'b1101); chk("mid_seg1", seg, 7'b1000000);
    value = 16'hFFFF; load = 1'b1;
    step(); chk("mid_an2", an, 4'b1101); chk("mid_seg2", seg, 7'b1000000);
    load = 1'b0;
    step(); chk("mid_an3", an, 4'b1101); chk("mid_seg3", seg, 7'b0001110);
    step(); chk("mid_an4", an, 4'b1011); chk("mid_seg4", seg, 7'b0001110);

    // Reset mid-frame overrides a simultaneous load.
    do_load(16'h5555, 4'b1111, 4'b0000);
    for (int i = 0; i < 5; i++) step();
    rst = 1'b1; load = 1'b1; value = 16'hFFFF;
    step();
    chk("abort_an", an, 4'hF);
    chk("abort_fd", frame_done, 1'b0);
    rst = 1'b0; load = 1'b0;
    step();
    chk("abort_seg", seg, 7'b1000000);
    chk("abort_dp", dp, 1'b1);
    for (int i = 0; i < 20; i++) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(63) == 0);
      load  = ($urandom_range(7) == 0);
      value = 16'($urandom);
      if ($urandom_range(3) == 0) value = value & 16'h00FF;
      dp_in = 4'($urandom);
      blank = ($urandom_range(3) == 0) ? 4'($urandom) : 4'b0000;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
